lsu_axi_master: RTL and testbench

- AXI-lite master for the RV32I load/store unit. Sits directly upstream of the data-memory AXI-lite slave.
- Accepts one core load/store request at a time and checks its alignment and funct3.
- For stores, builds byte-lane write data and wstrb; drives the AW/W/B or AR/R channel handshakes.
- Returns sign- or zero-extended load data, or an error flag, to the core.

---
 rtl/lsu_axi_master.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_master.sv
// ============================================================================
// Module  : lsu_axi_master
// Brief   : AXI-lite master for the RV32I load/store unit. Takes one core
//           request at a time, checks funct3 and alignment, drives AW/W/B or
//           AR/R and returns extended load data or an error flag.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu_axi_master #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // core request / response
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  // write address channel
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic [2:0]        o_awprot,
  // write data channel
  output logic              o_wvalid,
  input  logic              i_wready,
  output logic [31:0]       o_wdata,
  output logic [3:0]        o_wstrb,
  // write response channel
  input  logic              i_bvalid,
  output logic              o_bready,
  input  logic              i_bresp,
  // read address channel
  output logic              o_arvalid,
  input  logic              i_arready,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [2:0]        o_arprot,
  // read data channel
  input  logic              i_rvalid,
  output logic              o_rready,
  input  logic [31:0]       i_rdata,
  input  logic              i_rresp
);

  // Watchdog counter is one bit wider than needed so it can saturate above
  // TIMEOUT; a TIMEOUT of 0 still yields a legal 1-bit counter.
  localparam int                c_WD_W     = $clog2(TIMEOUT + 1) + 1;
  localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT);
  localparam logic [c_WD_W-1:0] c_WD_MAX   = '1;
  localparam logic [c_WD_W-1:0] c_WD_ONE   = c_WD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WR_B  = 3'd2,
    S_RD_AR = 3'd3,
    S_RD_R  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [31:0]         r_resp_rdata;
  logic                r_resp_err;
  logic                r_awvalid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_wvalid;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_bready;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_rready;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic [c_WD_W-1:0]   r_wd_cnt;

  logic                w_is_half;
  logic                w_is_word;
  logic                w_illegal;
  logic                w_misaligned;
  logic                w_bad;
  logic [ADDR_W-1:0]   w_line_addr;
  logic [31:0]         w_st_data;
  logic [3:0]          w_st_strb;
  logic [31:0]         w_ld_shift;
  logic [31:0]         w_ld_data;
  logic [c_WD_W-1:0]   w_wd_inc;
  logic                w_wd_expire;
  logic                w_aw_done;
  logic                w_w_done;

  // Upper address bits beyond the AXI window are intentionally ignored.
  generate
    if (ADDR_W < 32) begin : g_addr_unused
      logic w_unused_addr;
      assign w_unused_addr = ^i_req_addr[31:ADDR_W];
    end
  endgenerate

  // Request legality: size comes from funct3[1:0]; stores only allow 0..2,
  // loads additionally allow the unsigned forms 4 and 5.
  assign w_is_half    = (i_req_funct3[1:0] == 2'b01);
  assign w_is_word    = (i_req_funct3[1:0] == 2'b10);
  assign w_illegal    = i_req_we ? (i_req_funct3 > 3'd2)
                                 : ((i_req_funct3 == 3'd3) || (i_req_funct3 == 3'd6) ||
                                    (i_req_funct3 == 3'd7));
  assign w_misaligned = (w_is_half & i_req_addr[0]) |
                        (w_is_word & (i_req_addr[1:0] != 2'b00));
  assign w_bad        = w_illegal | w_misaligned;
  assign w_line_addr  = {i_req_addr[ADDR_W-1:2], 2'b00};

  // Store lane replication and byte strobes, computed from the live request.
  always_comb begin
    w_st_data = i_req_wdata;
    w_st_strb = 4'b1111;
    case (i_req_funct3[1:0])
      2'b00: begin
        w_st_data = {4{i_req_wdata[7:0]}};
        w_st_strb = 4'b0001 << i_req_addr[1:0];
      end
      2'b01: begin
        w_st_data = {2{i_req_wdata[15:0]}};
        w_st_strb = 4'b0011 << i_req_addr[1:0];
      end
      default: begin
        w_st_data = i_req_wdata;
        w_st_strb = 4'b1111;
      end
    endcase
  end

  // Load lane selection and sign/zero extension of the returned word.
  assign w_ld_shift = i_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_ld_shift;
    case (r_funct3)
      3'd0:    w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'd1:    w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'd4:    w_ld_data = {24'd0, w_ld_shift[7:0]};
      3'd5:    w_ld_data = {16'd0, w_ld_shift[15:0]};
      default: w_ld_data = w_ld_shift;
    endcase
  end

  // Saturating watchdog increment; expiry fires on the cycle the count
  // would reach TIMEOUT.
  assign w_wd_inc    = (r_wd_cnt == c_WD_MAX) ? r_wd_cnt : (r_wd_cnt + c_WD_ONE);
  assign w_wd_expire = (TIMEOUT != 0) && (w_wd_inc >= c_WD_LIMIT);

  // A write channel is finished once its valid has already dropped or is
  // handshaking in this cycle.
  assign w_aw_done = ~r_awvalid | i_awready;
  assign w_w_done  = ~r_wvalid  | i_wready;

  // Transaction FSM with all handshake and response outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_awvalid    <= 1'b0;
      r_awaddr     <= '0;
      r_wvalid     <= 1'b0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_rready     <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_wd_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
          if (i_req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_wd_cnt    <= '0;
            r_funct3    <= i_req_funct3;
            r_off       <= i_req_addr[1:0];
            if (w_bad) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (i_req_we) begin
              r_state   <= S_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= w_line_addr;
              r_wdata   <= w_st_data;
              r_wstrb   <= w_st_strb;
            end else begin
              r_state   <= S_RD_AR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_line_addr;
            end
          end
        end

        S_WR: begin
          r_wd_cnt <= w_wd_inc;
          if (w_wd_expire) begin
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else begin
            if (r_awvalid && i_awready) r_awvalid <= 1'b0;
            if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
            if (w_aw_done && w_w_done) begin
              r_state  <= S_WR_B;
              r_bready <= 1'b1;
            end
          end
        end

        S_WR_B: begin
          r_wd_cnt <= w_wd_inc;
          if (w_wd_expire) begin
            r_bready     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else if (i_bvalid) begin
            r_bready     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= ~i_bresp;
          end
        end

        S_RD_AR: begin
          r_wd_cnt <= w_wd_inc;
          if (w_wd_expire) begin
            r_arvalid    <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end

        S_RD_R: begin
          r_wd_cnt <= w_wd_inc;
          if (w_wd_expire) begin
            r_rready     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else if (i_rvalid) begin
            r_rready     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= ~i_rresp;
            r_resp_rdata <= i_rresp ? w_ld_data : 32'd0;
          end
        end

        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_awvalid    = r_awvalid;
  assign o_awaddr     = r_awaddr;
  assign o_awprot     = 3'b000;
  assign o_wvalid     = r_wvalid;
  assign o_wdata      = r_wdata;
  assign o_wstrb      = r_wstrb;
  assign o_bready     = r_bready;
  assign o_arvalid    = r_arvalid;
  assign o_araddr     = r_araddr;
  assign o_arprot     = 3'b000;
  assign o_rready     = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_lsu_axi_master.sv
// ============================================================================
// Module  : tb_lsu_axi_master
// Brief   : Directed self-checking bench for lsu_axi_master (TIMEOUT = 8).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsu_axi_master;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [2:0]        i_req_funct3;
  logic [31:0]       i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_resp_valid;
  logic [31:0]       o_resp_rdata;
  logic              o_resp_err;
  logic              o_awvalid;
  logic              i_awready;
  logic [ADDR_W-1:0] o_awaddr;
  logic [2:0]        o_awprot;
  logic              o_wvalid;
  logic              i_wready;
  logic [31:0]       o_wdata;
  logic [3:0]        o_wstrb;
  logic              i_bvalid;
  logic              o_bready;
  logic              i_bresp;
  logic              o_arvalid;
  logic              i_arready;
  logic [ADDR_W-1:0] o_araddr;
  logic [2:0]        o_arprot;
  logic              i_rvalid;
  logic              o_rready;
  logic [31:0]       i_rdata;
  logic              i_rresp;

  int checks   = 0;
  int failures = 0;

  // Results captured by the request driver.
  int                lat;
  logic [31:0]       rd;
  logic              er;
  int                aw_cyc;
  int                w_cyc;
  int                ar_cyc;
  logic [ADDR_W-1:0] cap_awaddr;
  logic [ADDR_W-1:0] cap_araddr;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_wstrb;

  lsu_axi_master #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_awvalid    (o_awvalid),
    .i_awready    (i_awready),
    .o_awaddr     (o_awaddr),
    .o_awprot     (o_awprot),
    .o_wvalid     (o_wvalid),
    .i_wready     (i_wready),
    .o_wdata      (o_wdata),
    .o_wstrb      (o_wstrb),
    .i_bvalid     (i_bvalid),
    .o_bready     (o_bready),
    .i_bresp      (i_bresp),
    .o_arvalid    (o_arvalid),
    .i_arready    (i_arready),
    .o_araddr     (o_araddr),
    .o_arprot     (o_arprot),
    .i_rvalid     (i_rvalid),
    .o_rready     (o_rready),
    .i_rdata      (i_rdata),
    .i_rresp      (i_rresp)
  );

  always #5 clk = ~clk;

  // Drives one request from a negedge and follows it to resp_valid (bounded).
  // lat = number of negedges after the accepting edge; 0 means no response.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    lat = 0; rd = '0; er = 1'b0;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
    cap_awaddr = '0; cap_araddr = '0; cap_wdata = '0; cap_wstrb = '0;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = a;
    i_req_wdata  = d;
    @(negedge clk);
    i_req_valid = 1'b0;
    n = 1;
    while (lat == 0 && n <= 40) begin
      if (o_awvalid) begin aw_cyc++; cap_awaddr = o_awaddr; end
      if (o_wvalid)  begin w_cyc++; cap_wdata = o_wdata; cap_wstrb = o_wstrb; end
      if (o_arvalid) begin ar_cyc++; cap_araddr = o_araddr; end
      if (o_resp_valid) begin
        lat = n; rd = o_resp_rdata; er = o_resp_err;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_req_ready, o_resp_valid, o_resp_err, o_awvalid, o_wvalid, o_bready, o_arvalid,
         o_rready, o_resp_rdata, o_awaddr, o_wdata, o_wstrb, o_araddr, o_awprot, o_arprot} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rv=%b aw=%b w=%b ar=%b rdata=%h required all zero",
               o_req_ready, o_resp_valid, o_awvalid, o_wvalid, o_arvalid, o_resp_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b required 1", o_req_ready);
    end
  endtask

  task automatic test_store_byte();
    issue(1'b1, 3'd0, 32'h0000_0006, 32'h0000_00A5);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL sb_latency: got %0d required 3", lat); end
    checks++;
    if (cap_awaddr !== 12'h004) begin failures++; $display("FAIL sb_awaddr: got %h required 004", cap_awaddr); end
    checks++;
    if (cap_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata: got %h required a5a5a5a5", cap_wdata); end
    checks++;
    if (cap_wstrb !== 4'b0100) begin failures++; $display("FAIL sb_wstrb: got %b required 0100", cap_wstrb); end
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sb_resp: err=%b rdata=%h required 0/0", er, rd); end
    checks++;
    if (aw_cyc !== 1 || w_cyc !== 1) begin failures++; $display("FAIL sb_valid_cycles: aw=%0d w=%0d required 1/1", aw_cyc, w_cyc); end
    @(negedge clk);
    checks++;
    if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++; $display("FAIL sb_pulse: resp_valid=%b req_ready=%b required 0/1", o_resp_valid, o_req_ready);
    end
  endtask

  task automatic test_store_half();
    issue(1'b1, 3'd1, 32'h0000_0002, 32'h1234_BEEF);
    checks++;
    if (cap_wdata !== 32'hBEEF_BEEF || cap_wstrb !== 4'b1100 || cap_awaddr !== 12'h000) begin
      failures++;
      $display("FAIL sh_payload: wdata=%h wstrb=%b awaddr=%h required beefbeef/1100/000", cap_wdata, cap_wstrb, cap_awaddr);
    end
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'd1, 3'd5, 3'd0, 3'd4, 3'd2};
    logic [31:0] adrs [5] = '{32'h102, 32'h102, 32'h103, 32'h101, 32'h100};
    logic [31:0] exps [5] = '{32'hFFFF_80FF, 32'h0000_80FF, 32'hFFFF_FF80, 32'h0000_0012, 32'h80FF_1234};
    i_rdata = 32'h80FF_1234;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'd0);
      checks++;
      if (lat !== 3 || er !== 1'b0 || rd !== exps[i] || cap_araddr !== 12'h100) begin
        failures++;
        $display("FAIL load_%0d: lat=%0d err=%b rdata=%h araddr=%h required 3/0/%h/100",
                 i, lat, er, rd, cap_araddr, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_split_write();
    i_wready     = 1'b0;
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = 3'd2;
    i_req_addr   = 32'h0000_0010;
    i_req_wdata  = 32'h1234_5678;
    @(negedge clk);
    i_req_valid = 1'b0;
    checks++;
    if (o_awvalid !== 1'b1 || o_wvalid !== 1'b1) begin
      failures++; $display("FAIL split_start: aw=%b w=%b required 1/1", o_awvalid, o_wvalid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_awvalid !== 1'b0 || o_wvalid !== 1'b1 || o_bready !== 1'b0 ||
          o_wdata !== 32'h1234_5678 || o_wstrb !== 4'b1111) begin
        failures++;
        $display("FAIL split_wait_%0d: aw=%b w=%b bready=%b wdata=%h wstrb=%b required 0/1/0/12345678/1111",
                 k, o_awvalid, o_wvalid, o_bready, o_wdata, o_wstrb);
      end
    end
    i_wready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_wvalid !== 1'b0 || o_bready !== 1'b1 || o_resp_valid !== 1'b0) begin
      failures++; $display("FAIL split_b: w=%b bready=%b rv=%b required 0/1/0", o_wvalid, o_bready, o_resp_valid);
    end
    @(negedge clk);
    checks++;
    if (o_resp_valid !== 1'b1 || o_resp_err !== 1'b0) begin
      failures++; $display("FAIL split_resp: rv=%b err=%b required 1/0", o_resp_valid, o_resp_err);
    end
    @(negedge clk);
    checks++;
    if (o_resp_valid !== 1'b0) begin failures++; $display("FAIL split_single_resp: rv=%b required 0", o_resp_valid); end
  endtask

  task automatic test_back_to_back();
    i_rdata = 32'hCAFE_F00D;
    issue(1'b1, 3'd2, 32'h0000_0020, 32'h0BAD_BEEF);
    checks++;
    if (lat !== 3 || o_req_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_first: lat=%0d req_ready=%b required 3/0", lat, o_req_ready);
    end
    @(negedge clk);
    issue(1'b0, 3'd2, 32'h0000_0020, 32'd0);
    checks++;
    if (lat !== 3 || rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      failures++; $display("FAIL b2b_second: lat=%0d rdata=%h err=%b required 3/cafef00d/0", lat, rd, er);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s  [4] = '{3'd2, 3'd3, 3'd1, 3'd6};
    logic [31:0] adrs [4] = '{32'h001, 32'h000, 32'h003, 32'h000};
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || (aw_cyc + w_cyc + ar_cyc) !== 0) begin
        failures++;
        $display("FAIL illegal_%0d: lat=%0d err=%b rdata=%h axi_valid_cycles=%0d required 1/1/0/0",
                 i, lat, er, rd, aw_cyc + w_cyc + ar_cyc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bus_error();
    i_rresp = 1'b0;
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    checks++;
    if (lat !== 3 || er !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL rresp_err: lat=%0d err=%b rdata=%h required 3/1/0", lat, er, rd);
    end
    i_rresp = 1'b1;
    @(negedge clk);
    i_bresp = 1'b0;
    issue(1'b1, 3'd2, 32'h0000_0100, 32'h5555_AAAA);
    checks++;
    if (lat !== 3 || er !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL bresp_err: lat=%0d err=%b rdata=%h required 3/1/0", lat, er, rd);
    end
    i_bresp = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    i_arready = 1'b0;
    issue(1'b0, 3'd2, 32'h0000_0200, 32'd0);
    checks++;
    if (lat !== 9 || ar_cyc !== 8 || er !== 1'b1 || rd !== 32'd0 || o_arvalid !== 1'b0) begin
      failures++;
      $display("FAIL timeout: lat=%0d ar_cycles=%0d err=%b rdata=%h arvalid=%b required 9/8/1/0/0",
               lat, ar_cyc, er, rd, o_arvalid);
    end
    i_arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_resp_valid !== 1'b0 || o_arvalid !== 1'b0 || o_rready !== 1'b0) begin
        failures++; $display("FAIL timeout_quiet_%0d: rv=%b ar=%b rready=%b required 0/0/0",
                             k, o_resp_valid, o_arvalid, o_rready);
      end
    end
  endtask

  task automatic test_reset_mid();
    i_bvalid     = 1'b0;
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = 3'd2;
    i_req_addr   = 32'h0000_0040;
    i_req_wdata  = 32'h7777_8888;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_bready !== 1'b1) begin failures++; $display("FAIL rstmid_wrb: bready=%b required 1", o_bready); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_req_ready, o_resp_valid, o_resp_err, o_awvalid, o_wvalid, o_bready, o_arvalid,
         o_rready, o_resp_rdata, o_awaddr, o_wdata, o_wstrb, o_araddr} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: ready=%b rv=%b bready=%b wdata=%h awaddr=%h required all zero",
               o_req_ready, o_resp_valid, o_bready, o_wdata, o_awaddr);
    end
    reset    = 1'b1;
    i_bvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_release: ready=%b rv=%b required 1/0", o_req_ready, o_resp_valid);
    end
    i_rdata = 32'h1357_9BDF;
    issue(1'b0, 3'd2, 32'h0000_0104, 32'd0);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h1357_9BDF || cap_araddr !== 12'h104) begin
      failures++; $display("FAIL rstmid_lw: lat=%0d err=%b rdata=%h araddr=%h required 3/0/13579bdf/104",
                           lat, er, rd, cap_araddr);
    end
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b0;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'd0;
    i_req_wdata  = 32'd0;
    i_awready    = 1'b1;
    i_wready     = 1'b1;
    i_bvalid     = 1'b1;
    i_bresp      = 1'b1;
    i_arready    = 1'b1;
    i_rvalid     = 1'b1;
    i_rresp      = 1'b1;
    i_rdata      = 32'd0;

    test_reset();
    test_store_byte();
    test_store_half();
    test_loads();
    test_split_write();
    test_back_to_back();
    test_illegal();
    test_bus_error();
    test_timeout();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
